// File: rtl/exec_pipe_ctrl_if.sv
// Handshake bundle between the Execute/Decode datapath and the pipeline
// sequencing controller.
interface exec_pipe_ctrl_if #(
  parameter int unsigned PC_SIZE   = 64,
  parameter int unsigned CNT_WIDTH = 32
);
  logic                 ex_valid;
  logic                 ex_ready;
  logic                 ex_is_branch;
  logic                 ex_taken;
  logic                 ex_a;
  logic [3:0]           ex_cond;
  logic [PC_SIZE-1:0]   ex_target;
  logic                 ex_is_load;
  logic [4:0]           ex_rd;
  logic                 id_valid;
  logic [4:0]           id_rs1;
  logic [4:0]           id_rs2;
  logic                 id_uses_rs2;

  logic                 if_stall;
  logic                 id_stall;
  logic                 ex_bubble;
  logic                 annul_slot;
  logic                 redirect;
  logic [PC_SIZE-1:0]   redirect_pc;
  logic [CNT_WIDTH-1:0] stall_cnt;
  logic [CNT_WIDTH-1:0] flush_cnt;

  // Datapath side: supplies pipeline status, consumes controls.
  modport master (
    output ex_valid, ex_ready, ex_is_branch, ex_taken, ex_a, ex_cond, ex_target,
           ex_is_load, ex_rd, id_valid, id_rs1, id_rs2, id_uses_rs2,
    input  if_stall, id_stall, ex_bubble, annul_slot, redirect, redirect_pc,
           stall_cnt, flush_cnt
  );

  // Controller side.
  modport slave (
    input  ex_valid, ex_ready, ex_is_branch, ex_taken, ex_a, ex_cond, ex_target,
           ex_is_load, ex_rd, id_valid, id_rs1, id_rs2, id_uses_rs2,
    output if_stall, id_stall, ex_bubble, annul_slot, redirect, redirect_pc,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/exec_pipe_ctrl.sv
// Pipeline sequencing controller around Execute: memory-wait stalls, load-use
// bubbles, taken-branch redirects, delay-slot annulment and perf counters.
module exec_pipe_ctrl #(
  parameter int unsigned PC_SIZE   = 64,
  parameter int unsigned CNT_WIDTH = 32
) (
  input logic              clk,
  input logic              reset,
  exec_pipe_ctrl_if.slave  bus
);

  localparam logic [3:0] COND_BA = 4'b1000;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MEM_WAIT  = 2'd1,
    LD_BUBBLE = 2'd2,
    REDIRECT  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic                 redirect_q;
  logic [PC_SIZE-1:0]   redirect_pc_q, redirect_pc_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, flush_cnt_q;

  logic memwait, take, annul, lduse, ex_fire;
  logic if_stall_c, id_stall_c, ex_bubble_c, annul_slot_c;

  assign ex_fire = bus.ex_valid & bus.ex_ready;
  assign memwait = bus.ex_valid & ~bus.ex_ready;
  assign take    = ex_fire & bus.ex_is_branch & bus.ex_taken;
  assign annul   = ex_fire & bus.ex_is_branch & bus.ex_a &
                   (~bus.ex_taken | (bus.ex_cond == COND_BA));
  assign lduse   = ex_fire & bus.ex_is_load & (bus.ex_rd != 5'd0) & bus.id_valid &
                   ((bus.id_rs1 == bus.ex_rd) |
                    (bus.id_uses_rs2 & (bus.id_rs2 == bus.ex_rd)));

  // Next-state and same-cycle control decode.
  always_comb begin
    state_d       = state_q;
    redirect_pc_d = redirect_pc_q;
    if_stall_c    = 1'b0;
    id_stall_c    = 1'b0;
    ex_bubble_c   = 1'b0;
    annul_slot_c  = 1'b0;
    unique case (state_q)
      RUN: begin
        annul_slot_c = annul;
        if (memwait) begin
          if_stall_c = 1'b1;
          id_stall_c = 1'b1;
          state_d    = MEM_WAIT;
        end else if (take) begin
          redirect_pc_d = bus.ex_target;
          state_d       = REDIRECT;
        end else if (lduse) begin
          if_stall_c  = 1'b1;
          id_stall_c  = 1'b1;
          ex_bubble_c = 1'b1;
          state_d     = LD_BUBBLE;
        end
      end
      MEM_WAIT: begin
        if (!bus.ex_ready) begin
          if_stall_c = 1'b1;
          id_stall_c = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      LD_BUBBLE: state_d = RUN;
      REDIRECT: begin
        // Hold Fetch so the wrong-path fetch issued alongside the redirect is dropped.
        if_stall_c = 1'b1;
        if (memwait) begin
          id_stall_c = 1'b1;
          state_d    = MEM_WAIT;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= RUN;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      redirect_q    <= (state_d == REDIRECT);
      redirect_pc_q <= redirect_pc_d;
      stall_cnt_q   <= stall_cnt_q + CNT_WIDTH'(if_stall_c);
      flush_cnt_q   <= flush_cnt_q + CNT_WIDTH'(redirect_q);
    end
  end

  assign bus.if_stall    = if_stall_c;
  assign bus.id_stall    = id_stall_c;
  assign bus.ex_bubble   = ex_bubble_c;
  assign bus.annul_slot  = annul_slot_c;
  assign bus.redirect    = redirect_q;
  assign bus.redirect_pc = redirect_pc_q;
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_exec_pipe_ctrl.sv
// Directed bench for exec_pipe_ctrl; 4-bit counters so the wrap case is short.
module tb_exec_pipe_ctrl;

  localparam int unsigned PC_SIZE   = 64;
  localparam int unsigned CNT_WIDTH = 4;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  exec_pipe_ctrl_if #(.PC_SIZE(PC_SIZE), .CNT_WIDTH(CNT_WIDTH)) bus ();

  exec_pipe_ctrl #(.PC_SIZE(PC_SIZE), .CNT_WIDTH(CNT_WIDTH)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.ex_valid     = 1'b0;
    bus.ex_ready     = 1'b1;
    bus.ex_is_branch = 1'b0;
    bus.ex_taken     = 1'b0;
    bus.ex_a         = 1'b0;
    bus.ex_cond      = 4'd0;
    bus.ex_target    = '0;
    bus.ex_is_load   = 1'b0;
    bus.ex_rd        = 5'd0;
    bus.id_valid     = 1'b0;
    bus.id_rs1       = 5'd0;
    bus.id_rs2       = 5'd0;
    bus.id_uses_rs2  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    tick();
  endtask

  task automatic set_load(input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic uses2, input logic rdy);
    idle();
    bus.ex_valid    = 1'b1;
    bus.ex_ready    = rdy;
    bus.ex_is_load  = 1'b1;
    bus.ex_rd       = rd;
    bus.id_valid    = 1'b1;
    bus.id_rs1      = rs1;
    bus.id_rs2      = rs2;
    bus.id_uses_rs2 = uses2;
  endtask

  task automatic set_branch(input logic tkn, input logic a, input logic [3:0] cond,
                            input logic [63:0] tgt);
    idle();
    bus.ex_valid     = 1'b1;
    bus.ex_is_branch = 1'b1;
    bus.ex_taken     = tkn;
    bus.ex_a         = a;
    bus.ex_cond      = cond;
    bus.ex_target    = tgt;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    idle();
    reset = 1'b1;
    #12;
    check("rst_if_stall", 64'(bus.if_stall), 64'd0);
    check("rst_id_stall", 64'(bus.id_stall), 64'd0);
    check("rst_ex_bubble", 64'(bus.ex_bubble), 64'd0);
    check("rst_annul", 64'(bus.annul_slot), 64'd0);
    check("rst_redirect", 64'(bus.redirect), 64'd0);
    check("rst_redirect_pc", 64'(bus.redirect_pc), 64'd0);
    check("rst_stall_cnt", 64'(bus.stall_cnt), 64'd0);
    check("rst_flush_cnt", 64'(bus.flush_cnt), 64'd0);
    reset = 1'b0;
    tick();

    // Load-use on rs1, then on rs2, and the non-hazard variants.
    set_load(5'd5, 5'd5, 5'd0, 1'b0, 1'b1);
    @(negedge clk);
    check("lu_if_stall", 64'(bus.if_stall), 64'd1);
    check("lu_id_stall", 64'(bus.id_stall), 64'd1);
    check("lu_bubble", 64'(bus.ex_bubble), 64'd1);
    tick();
    @(negedge clk);
    check("lu_after_stall", 64'(bus.if_stall), 64'd0);
    check("lu_after_bubble", 64'(bus.ex_bubble), 64'd0);
    check("lu_stall_cnt", 64'(bus.stall_cnt), 64'd1);
    tick();
    set_load(5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    @(negedge clk);
    check("lu_r0_stall", 64'(bus.if_stall), 64'd0);
    check("lu_r0_bubble", 64'(bus.ex_bubble), 64'd0);
    tick();
    set_load(5'd7, 5'd3, 5'd7, 1'b1, 1'b1);
    @(negedge clk);
    check("lu_rs2_bubble", 64'(bus.ex_bubble), 64'd1);
    tick();
    tick();
    set_load(5'd7, 5'd3, 5'd7, 1'b0, 1'b1);
    @(negedge clk);
    check("lu_rs2_unused", 64'(bus.ex_bubble), 64'd0);
    tick();
    idle();
    @(negedge clk);
    check("lu_total_cnt", 64'(bus.stall_cnt), 64'd2);

    // Taken branch: redirect one cycle later for exactly one cycle.
    do_reset();
    set_branch(1'b1, 1'b0, 4'b0001, 64'h1000);
    @(negedge clk);
    check("br_redirect_early", 64'(bus.redirect), 64'd0);
    check("br_annul", 64'(bus.annul_slot), 64'd0);
    tick();
    idle();
    @(negedge clk);
    check("br_redirect", 64'(bus.redirect), 64'd1);
    check("br_redirect_pc", 64'(bus.redirect_pc), 64'h1000);
    check("br_if_stall", 64'(bus.if_stall), 64'd1);
    tick();
    @(negedge clk);
    check("br_redirect_drop", 64'(bus.redirect), 64'd0);
    check("br_flush_cnt", 64'(bus.flush_cnt), 64'd1);
    check("br_stall_cnt", 64'(bus.stall_cnt), 64'd1);

    // Annul cases.
    do_reset();
    set_branch(1'b0, 1'b1, 4'b0001, 64'h0);
    @(negedge clk);
    check("an_nt_annul", 64'(bus.annul_slot), 64'd1);
    tick();
    idle();
    @(negedge clk);
    check("an_nt_redirect", 64'(bus.redirect), 64'd0);
    tick();
    set_branch(1'b1, 1'b1, 4'b1000, 64'h2000);
    @(negedge clk);
    check("an_ba_annul", 64'(bus.annul_slot), 64'd1);
    tick();
    idle();
    @(negedge clk);
    check("an_ba_redirect", 64'(bus.redirect), 64'd1);
    check("an_ba_pc", 64'(bus.redirect_pc), 64'h2000);
    tick();
    set_branch(1'b1, 1'b1, 4'b0001, 64'h3000);
    @(negedge clk);
    check("an_tk_annul", 64'(bus.annul_slot), 64'd0);
    tick();
    idle();
    @(negedge clk);
    check("an_tk_redirect", 64'(bus.redirect), 64'd1);
    tick();
    set_branch(1'b0, 1'b1, 4'b0000, 64'h0);
    @(negedge clk);
    check("an_bn_annul", 64'(bus.annul_slot), 64'd1);
    tick();

    // Memory wait overlapping a load-use hazard.
    do_reset();
    set_load(5'd5, 5'd5, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mw_if_stall", 64'(bus.if_stall), 64'd1);
      check("mw_bubble", 64'(bus.ex_bubble), 64'd0);
      tick();
    end
    bus.ex_ready = 1'b1;
    @(negedge clk);
    check("mw_exit_stall", 64'(bus.if_stall), 64'd0);
    tick();
    @(negedge clk);
    check("mw_lu_bubble", 64'(bus.ex_bubble), 64'd1);
    check("mw_lu_stall", 64'(bus.if_stall), 64'd1);
    tick();
    @(negedge clk);
    check("mw_after_bubble", 64'(bus.ex_bubble), 64'd0);
    tick();
    idle();
    check("mw_stall_cnt", 64'(bus.stall_cnt), 64'd4);

    // Asynchronous reset while in MEM_WAIT.
    do_reset();
    set_load(5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    idle();
    bus.ex_ready = 1'b0;
    #1;
    check("rmw_in_wait", 64'(bus.if_stall), 64'd1);
    check("rmw_cnt_before", 64'(bus.stall_cnt), 64'd1);
    reset = 1'b1;
    #1;
    check("rmw_if_stall", 64'(bus.if_stall), 64'd0);
    check("rmw_id_stall", 64'(bus.id_stall), 64'd0);
    check("rmw_stall_cnt", 64'(bus.stall_cnt), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rmw_run", 64'(bus.if_stall), 64'd0);
    tick();
    idle();

    // Asynchronous reset while redirecting drops the pending redirect.
    set_branch(1'b1, 1'b0, 4'b0001, 64'h4000);
    tick();
    idle();
    #1;
    check("rrd_active", 64'(bus.redirect), 64'd1);
    reset = 1'b1;
    #1;
    check("rrd_redirect", 64'(bus.redirect), 64'd0);
    check("rrd_pc", 64'(bus.redirect_pc), 64'd0);
    check("rrd_flush_cnt", 64'(bus.flush_cnt), 64'd0);
    check("rrd_if_stall", 64'(bus.if_stall), 64'd0);
    reset = 1'b0;
    tick();
    @(negedge clk);
    check("rrd_no_pulse", 64'(bus.redirect), 64'd0);
    tick();

    // 17 redirects wrap a 4-bit counter to 1.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      set_branch(1'b1, 1'b0, 4'b0001, 64'(i));
      tick();
      idle();
      tick();
    end
    @(negedge clk);
    check("wrap_flush_cnt", 64'(bus.flush_cnt), 64'd1);
    check("wrap_stall_cnt", 64'(bus.stall_cnt), 64'd1);
    check("wrap_last_pc", 64'(bus.redirect_pc), 64'd16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
